// File: rtl/mips_isa_pkg.sv
// MIPS instruction-subset definitions shared by the program loader and the main decoder:
// request kind codes, opcodes, R-type funct codes and loader FSM states.
package mips_isa_pkg;

   typedef enum logic [3:0] {
      K_ADD  = 4'd0,
      K_SUB  = 4'd1,
      K_AND  = 4'd2,
      K_OR   = 4'd3,
      K_SLT  = 4'd4,
      K_LW   = 4'd5,
      K_SW   = 4'd6,
      K_BEQ  = 4'd7,
      K_ADDI = 4'd8,
      K_ORI  = 4'd9,
      K_J    = 4'd10,
      K_JAL  = 4'd11
   } kind_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FIN
   } state_e;

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {OP_RTYPE, rs, rt, rd, 5'b00000, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/mips_instr_encoder.sv
// Combinational encoder: request kind plus operand fields to a 32-bit MIPS word.
// Kinds outside the supported subset produce a zero word with o_legal low.
module mips_instr_encoder
   import mips_isa_pkg::*;
(
   input  logic [3:0]  i_kind,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [25:0] i_imm,
   output logic [31:0] o_word,
   output logic        o_legal
);

   always_comb begin
      o_word  = '0;
      o_legal = 1'b1;
      case (i_kind)
         K_ADD:   o_word = enc_r(i_rs, i_rt, i_rd, FN_ADD);
         K_SUB:   o_word = enc_r(i_rs, i_rt, i_rd, FN_SUB);
         K_AND:   o_word = enc_r(i_rs, i_rt, i_rd, FN_AND);
         K_OR:    o_word = enc_r(i_rs, i_rt, i_rd, FN_OR);
         K_SLT:   o_word = enc_r(i_rs, i_rt, i_rd, FN_SLT);
         K_LW:    o_word = enc_i(OP_LW,   i_rs, i_rt, i_imm[15:0]);
         K_SW:    o_word = enc_i(OP_SW,   i_rs, i_rt, i_imm[15:0]);
         K_BEQ:   o_word = enc_i(OP_BEQ,  i_rs, i_rt, i_imm[15:0]);
         K_ADDI:  o_word = enc_i(OP_ADDI, i_rs, i_rt, i_imm[15:0]);
         K_ORI:   o_word = enc_i(OP_ORI,  i_rs, i_rt, i_imm[15:0]);
         K_J:     o_word = {OP_J,   i_imm};
         K_JAL:   o_word = {OP_JAL, i_imm};
         default: o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_program_loader.sv
// Session-based loader: accepts symbolic instruction requests, encodes them and writes
// them to sequential instruction-memory addresses starting at 0, one per cycle.
module mips_program_loader
   import mips_isa_pkg::*;
#(
   parameter int unsigned AW    = 6,
   parameter int unsigned DEPTH = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_kind,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_rd,
   input  logic [25:0]   in_imm,
   input  logic          in_last,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   count,
   output logic          err_illegal,
   output logic          err_full
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   state_e        r_state;
   state_e        w_next;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [AW:0]   r_count;
   logic          r_err_illegal;
   logic          r_err_full;
   logic [31:0]   w_word;
   logic          w_legal;
   logic          w_accept;
   logic          w_full;

   mips_instr_encoder u_enc (
      .i_kind  (in_kind),
      .i_rs    (in_rs),
      .i_rt    (in_rt),
      .i_rd    (in_rd),
      .i_imm   (in_imm),
      .o_word  (w_word),
      .o_legal (w_legal)
   );

   assign w_accept = in_valid & in_ready;
   assign w_full   = (r_count == LP_DEPTH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next = ST_LOAD;
         ST_LOAD: if (w_accept && (w_full || in_last)) w_next = ST_FIN;
         ST_FIN:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (r_state == ST_LOAD);
      busy     = (r_state == ST_LOAD) || (r_state == ST_FIN);
      done     = (r_state == ST_FIN);
   end

   // A full-table request is dropped before legality is considered; it still ends the session.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_count       <= '0;
         r_err_illegal <= 1'b0;
         r_err_full    <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (r_state == ST_IDLE && start) begin
            r_count       <= '0;
            r_err_illegal <= 1'b0;
            r_err_full    <= 1'b0;
         end else if (w_accept) begin
            if (w_full) begin
               r_err_full <= 1'b1;
            end else if (!w_legal) begin
               r_err_illegal <= 1'b1;
            end else begin
               r_we    <= 1'b1;
               r_addr  <= r_count[AW-1:0];
               r_wdata <= w_word;
               r_count <= r_count + 1'b1;
            end
         end
      end
   end

   assign imem_we     = r_we;
   assign imem_addr   = r_addr;
   assign imem_wdata  = r_wdata;
   assign count       = r_count;
   assign err_illegal = r_err_illegal;
   assign err_full    = r_err_full;

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed bench for mips_program_loader (DEPTH=4 so the full-table case is reachable).
module tb_mips_program_loader;
   import mips_isa_pkg::*;

   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_kind;
   logic [4:0]    in_rs;
   logic [4:0]    in_rt;
   logic [4:0]    in_rd;
   logic [25:0]   in_imm;
   logic          in_last;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          busy;
   logic          done;
   logic [AW:0]   count;
   logic          err_illegal;
   logic          err_full;

   int total = 0;
   int bad   = 0;

   mips_program_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_kind     (in_kind),
      .in_rs       (in_rs),
      .in_rt       (in_rt),
      .in_rd       (in_rd),
      .in_imm      (in_imm),
      .in_last     (in_last),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .busy        (busy),
      .done        (done),
      .count       (count),
      .err_illegal (err_illegal),
      .err_full    (err_full)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_kind = '0;
      in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
   endtask

   task automatic req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [25:0] imm, input logic last);
      in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
      in_imm = imm; in_last = last;
   endtask

   // Leaves the bench 1 time unit after the edge that entered LOAD.
   task automatic pulse_start();
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({in_ready, imem_we, busy, done, err_illegal, err_full} !== 6'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=000000",
                  {in_ready, imem_we, busy, done, err_illegal, err_full});
      end
      total++;
      if ({imem_addr, imem_wdata, count} !== '0) begin
         bad++;
         $display("FAIL reset_data addr=%h wdata=%h count=%0d exp all zero", imem_addr, imem_wdata, count);
      end
      rst = 1'b0;
      req(K_ADD, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1);
      @(posedge clk); #1;
      total++;
      if ({in_ready, imem_we, busy, count} !== '0) begin
         bad++;
         $display("FAIL idle_ignores_valid rdy=%b we=%b busy=%b count=%0d exp 0", in_ready, imem_we, busy, count);
      end
      idle_inputs();
   endtask

   task automatic test_single_add();
      pulse_start();
      total++;
      if ({in_ready, busy, done} !== 3'b110) begin
         bad++;
         $display("FAIL load_state got rdy/busy/done=%b exp=110", {in_ready, busy, done});
      end
      req(K_ADD, 5'd1, 5'd2, 5'd3, 26'h2AAAAAA, 1'b1);
      @(posedge clk); #1;
      idle_inputs();
      total++;
      if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 6'd0, 32'h00221820}) begin
         bad++;
         $display("FAIL add_write we=%b addr=%0d wdata=%h exp we=1 addr=0 wdata=00221820", imem_we, imem_addr, imem_wdata);
      end
      total++;
      if ({done, busy, in_ready, count} !== {3'b110, 7'd1}) begin
         bad++;
         $display("FAIL add_fin done=%b busy=%b rdy=%b count=%0d exp 1 1 0 1", done, busy, in_ready, count);
      end
      @(posedge clk); #1;
      total++;
      if ({imem_we, done, busy, imem_addr, imem_wdata} !== {3'b000, 6'd0, 32'h00221820}) begin
         bad++;
         $display("FAIL add_after we=%b done=%b busy=%b addr=%0d wdata=%h exp 0 0 0 0 00221820",
                  imem_we, done, busy, imem_addr, imem_wdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  k[3]   = '{K_LW, K_BEQ, K_ORI};
      logic [4:0]  rs[3]  = '{5'd9, 5'd1, 5'd0};
      logic [4:0]  rt[3]  = '{5'd8, 5'd2, 5'd5};
      logic [4:0]  rd[3]  = '{5'd31, 5'd17, 5'd3};
      logic [25:0] imm[3] = '{26'h3FF0004, 26'h000FFFF, 26'h155ABCD};
      logic [31:0] exp[3] = '{32'h8D280004, 32'h1022FFFF, 32'h3405ABCD};
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         req(k[i], rs[i], rt[i], rd[i], imm[i], (i == 2));
         start = (i == 1);
         @(posedge clk); #1;
         total++;
         if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 6'(i), exp[i]}) begin
            bad++;
            $display("FAIL b2b_write%0d we=%b addr=%0d wdata=%h exp we=1 addr=%0d wdata=%h",
                     i, imem_we, imem_addr, imem_wdata, i, exp[i]);
         end
         total++;
         if ({count, done} !== {7'(i + 1), (i == 2)}) begin
            bad++;
            $display("FAIL b2b_count%0d count=%0d done=%b exp count=%0d done=%b", i, count, done, i + 1, (i == 2));
         end
      end
      idle_inputs();
      @(posedge clk); #1;
   endtask

   task automatic test_jumps();
      logic [3:0]  k[2]   = '{K_J, K_JAL};
      logic [4:0]  rs[2]  = '{5'd5, 5'd31};
      logic [31:0] exp[2] = '{32'h08000010, 32'h0C000010};
      pulse_start();
      for (int i = 0; i < 2; i++) begin
         req(k[i], rs[i], 5'd7, 5'd9, 26'h0000010, (i == 1));
         @(posedge clk); #1;
         total++;
         if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 6'(i), exp[i]}) begin
            bad++;
            $display("FAIL jump_write%0d we=%b addr=%0d wdata=%h exp we=1 addr=%0d wdata=%h",
                     i, imem_we, imem_addr, imem_wdata, i, exp[i]);
         end
      end
      idle_inputs();
      @(posedge clk); #1;
   endtask

   task automatic test_illegal();
      pulse_start();
      req(K_ADD, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
      @(posedge clk); #1;
      req(4'd14, 5'd4, 5'd5, 5'd6, 26'h1234, 1'b0);
      @(posedge clk); #1;
      total++;
      if ({imem_we, err_illegal, count, imem_addr, busy} !== {1'b0, 1'b1, 7'd1, 6'd0, 1'b1}) begin
         bad++;
         $display("FAIL illegal_drop we=%b err=%b count=%0d addr=%0d busy=%b exp 0 1 1 0 1",
                  imem_we, err_illegal, count, imem_addr, busy);
      end
      req(K_ADD, 5'd4, 5'd5, 5'd6, 26'd0, 1'b1);
      @(posedge clk); #1;
      idle_inputs();
      total++;
      if ({imem_we, imem_addr, imem_wdata, done, count, err_illegal} !== {1'b1, 6'd1, 32'h00853020, 1'b1, 7'd2, 1'b1}) begin
         bad++;
         $display("FAIL illegal_next we=%b addr=%0d wdata=%h done=%b count=%0d err=%b exp 1 1 00853020 1 2 1",
                  imem_we, imem_addr, imem_wdata, done, count, err_illegal);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_full();
      pulse_start();
      req(K_ADD, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total++;
         if ({imem_we, imem_addr, count, err_full} !== {1'b1, 6'(i), 7'(i + 1), 1'b0}) begin
            bad++;
            $display("FAIL full_write%0d we=%b addr=%0d count=%0d errf=%b exp 1 %0d %0d 0",
                     i, imem_we, imem_addr, count, err_full, i, i + 1);
         end
      end
      @(posedge clk); #1;
      idle_inputs();
      total++;
      if ({imem_we, err_full, done, count, imem_addr} !== {3'b011, 7'd4, 6'd3}) begin
         bad++;
         $display("FAIL full_drop we=%b errf=%b done=%b count=%0d addr=%0d exp 0 1 1 4 3",
                  imem_we, err_full, done, count, imem_addr);
      end
      @(posedge clk); #1;
      total++;
      if ({busy, done, err_full} !== 3'b001) begin
         bad++;
         $display("FAIL full_idle busy=%b done=%b errf=%b exp 0 0 1", busy, done, err_full);
      end
   endtask

   task automatic test_reset_midsession();
      pulse_start();
      total++;
      if ({err_full, err_illegal, count} !== '0) begin
         bad++;
         $display("FAIL start_clears errf=%b erri=%b count=%0d exp 0 0 0", err_full, err_illegal, count);
      end
      req(K_ADD, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
      @(posedge clk); #1;
      req(4'd15, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
      @(posedge clk); #1;
      req(K_SUB, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
      @(posedge clk); #1;
      total++;
      if ({imem_we, imem_addr, imem_wdata, count, err_illegal} !== {1'b1, 6'd1, 32'h00221822, 7'd2, 1'b1}) begin
         bad++;
         $display("FAIL pre_reset we=%b addr=%0d wdata=%h count=%0d erri=%b exp 1 1 00221822 2 1",
                  imem_we, imem_addr, imem_wdata, count, err_illegal);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({in_ready, imem_we, busy, done, err_illegal, err_full, imem_addr, imem_wdata, count} !== '0) begin
         bad++;
         $display("FAIL async_reset rdy=%b we=%b busy=%b done=%b erri=%b errf=%b addr=%0d wdata=%h count=%0d exp all 0",
                  in_ready, imem_we, busy, done, err_illegal, err_full, imem_addr, imem_wdata, count);
      end
      idle_inputs();
      @(posedge clk); #1;
      rst = 1'b0;
      pulse_start();
      req(K_OR, 5'd7, 5'd8, 5'd9, 26'd0, 1'b1);
      @(posedge clk); #1;
      idle_inputs();
      total++;
      if ({imem_we, imem_addr, imem_wdata, count, err_illegal, done} !== {1'b1, 6'd0, 32'h00E84825, 7'd1, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL restart we=%b addr=%0d wdata=%h count=%0d erri=%b done=%b exp 1 0 00e84825 1 0 1",
                  imem_we, imem_addr, imem_wdata, count, err_illegal, done);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_back_to_back();
      test_jumps();
      test_illegal();
      test_full();
      test_reset_midsession();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
